// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port LC-3 data memory.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin ties instead of B priority.
module dmem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              win_b_q, win_b_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  logic              grant_b;
  logic              sel_we;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_b_q, last_b_d;
`else
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);
  logic [SW-1:0] starve_q, starve_d;
`endif

  always_comb begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    grant_b  = b_req & (~a_req | ~last_b_q);
    last_b_d = last_b_q;
`else
    // A is forced through once it has lost LIM arbitrations in a row
    grant_b  = b_req & (~a_req | (starve_q != LIM));
    starve_d = starve_q;
`endif
    sel_we      = grant_b ? b_we : a_we;
    state_d     = state_q;
    win_b_d     = win_b_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
`ifndef DMEM_ARB_ROUND_ROBIN_EN
        if (!a_req || !grant_b)
          starve_d = '0;
        else if (starve_q != LIM)
          starve_d = starve_q + 1'b1;
`endif
        if (a_req || b_req) begin
          win_b_d     = grant_b;
          mem_addr_d  = grant_b ? b_addr : a_addr;
          mem_wdata_d = grant_b ? b_wdata : a_wdata;
          mem_write_d = sel_we;
          mem_read_d  = ~sel_we;
          state_d     = S_ACCESS;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
          last_b_d    = grant_b;
`endif
        end
      end
      S_ACCESS: begin
        if (mem_read_q) begin
          if (win_b_q) b_rdata_d = mem_rdata;
          else         a_rdata_d = mem_rdata;
        end
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        a_ack_d     = ~win_b_q;
        b_ack_d     = win_b_q;
        state_d     = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      win_b_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_b_q    <= 1'b1;
`else
      starve_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      win_b_q     <= win_b_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_b_q    <= last_b_d;
`else
      starve_q    <= starve_d;
`endif
    end
  end

  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q == S_ACCESS) | (state_q == S_DONE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a small behavioural memory.
// Expected ack order/data are queued as each stimulus is driven.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [15:0] a_addr = '0, a_wdata = '0;
  logic        a_ack;
  logic [15:0] a_rdata;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [15:0] b_addr = '0, b_wdata = '0;
  logic        b_ack;
  logic [15:0] b_rdata;
  logic        mem_read, mem_write;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  logic [15:0] mem [256];
  logic        init_mem = 1'b1;
  logic [16:0] sb [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          a_left, b_left;
  int          a_cyc, b_cyc, a_acks, wcnt;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_init(input int i);
    logic [7:0] lo;
    lo = 8'(i);
    return (i == 13) ? 16'h000A : {8'hC0, lo};
  endfunction

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= mem_init(i);
    end else if (mem_write) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  assign mem_rdata = mem[mem_addr[7:0]];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic port, input logic [15:0] d);
    sb.push_back({port, d});
  endtask

  task automatic sb_pop(input logic port, input logic [15:0] d);
    logic [16:0] e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk("sb_port", 32'(port), 32'(e[16]));
    chk("sb_data", 32'(d), 32'(e[15:0]));
  endtask

  task automatic run(input int max);
    int n = 0;
    wcnt = 0;
    a_acks = 0;
    while ((a_req || b_req) && n < max) begin
      @(negedge clk);
      n++;
      if (mem_write) wcnt++;
      if (a_ack) begin
        sb_pop(1'b0, a_rdata);
        a_cyc = cyc;
        a_acks++;
        a_left--;
        if (a_left <= 0) a_req = 1'b0;
      end
      if (b_ack) begin
        sb_pop(1'b1, b_rdata);
        b_cyc = cyc;
        b_left--;
        if (b_left <= 0) b_req = 1'b0;
      end
    end
    chk("run_done", 32'(a_req | b_req), 32'd0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    init_mem = 1'b0;
    do_reset();
    chk("rst_out",
        {a_ack, b_ack, a_rdata, b_rdata[7:0], mem_read, mem_write, busy},
        32'd0);
    chk("rst_bus", {mem_addr, mem_wdata}, 32'd0);

    // B read of x300D, cycle-exact
    b_req = 1'b1; b_we = 1'b0; b_addr = 16'h300D;
    push(1'b1, 16'h000A);
    @(negedge clk);
    chk("t1_rd", 32'(mem_read), 32'd1);
    chk("t1_addr", 32'(mem_addr), 32'h300D);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_aack", 32'(a_ack), 32'd0);
    @(negedge clk);
    chk("t1_back", 32'(b_ack), 32'd1);
    chk("t1_aack2", 32'(a_ack), 32'd0);
    sb_pop(1'b1, b_rdata);
    b_req = 1'b0;
    @(negedge clk);
    chk("t1_ackoff", 32'(b_ack), 32'd0);

    // A write then A read back
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'h300C; a_wdata = 16'h1234;
    a_left = 1;
    push(1'b0, 16'h0000);
    run(20);
    chk("wr_cycles", 32'(wcnt), 32'd1);
    chk("wr_acks", 32'(a_acks), 32'd1);
    a_req = 1'b1; a_we = 1'b0; a_left = 1;
    push(1'b0, 16'h1234);
    run(20);

    // simultaneous reads straight after reset
    do_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h3001; a_left = 1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 16'h3002; b_left = 1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    push(1'b0, 16'hC001);
    push(1'b1, 16'hC002);
`else
    push(1'b1, 16'hC002);
    push(1'b0, 16'hC001);
`endif
    run(30);
    chk("tie_gap", 32'((a_cyc > b_cyc) ? a_cyc - b_cyc : b_cyc - a_cyc),
        32'd3);

    // B hammering while A waits
    a_req = 1'b1; a_addr = 16'h3020; a_left = 2;
    b_req = 1'b1; b_addr = 16'h3010; b_left = 5;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    push(1'b0, 16'hC020); push(1'b1, 16'hC010);
    push(1'b0, 16'hC020); push(1'b1, 16'hC010);
    push(1'b1, 16'hC010); push(1'b1, 16'hC010);
    push(1'b1, 16'hC010);
`else
    push(1'b1, 16'hC010); push(1'b1, 16'hC010);
    push(1'b1, 16'hC010); push(1'b1, 16'hC010);
    push(1'b0, 16'hC020); push(1'b1, 16'hC010);
    push(1'b0, 16'hC020);
`endif
    run(100);

    // reset during ACCESS of a B read
    b_req = 1'b1; b_we = 1'b0; b_addr = 16'h300D;
    @(negedge clk);
    chk("rm_access", 32'(mem_read), 32'd1);
    rst = 1'b1;
    b_req = 1'b0;
    @(negedge clk);
    chk("rm_ack", 32'(b_ack), 32'd0);
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_read", 32'(mem_read), 32'd0);
    chk("rm_rdata", 32'(b_rdata), 32'd0);
    rst = 1'b0;

    // idle bus
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle", {mem_read, mem_write, busy, a_ack, b_ack}, 32'd0);
    end

    chk("sb_left", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
